// File: rtl/uart_ahb_cmd_bridge_if.sv
// Signal bundle between the UART command bridge and its environment: the UART byte
// stream, the external master port and the status strobes.
interface uart_ahb_cmd_bridge_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] ext_addr;
   logic [1:0]  ext_slv_sel_in;
   logic [31:0] ext_mast_din;
   logic        ext_wr;
   logic        ext_enable;
   logic        ext_hbusreq_in;
   logic [31:0] ext_mast_dout;
   logic        busy;
   logic        rx_drop;

   modport master (
      input  rx_data, rx_valid, tx_ready, ext_mast_dout,
      output tx_data, tx_valid, ext_addr, ext_slv_sel_in, ext_mast_din,
             ext_wr, ext_enable, ext_hbusreq_in, busy, rx_drop
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, ext_mast_dout,
      input  tx_data, tx_valid, ext_addr, ext_slv_sel_in, ext_mast_din,
             ext_wr, ext_enable, ext_hbusreq_in, busy, rx_drop
   );
endinterface

// File: rtl/uart_ahb_cmd_bridge.sv
// UART command frames (cmd, 4 address bytes, optional 4 data bytes) turned into one
// external master transfer plus a UART response. Define BRIDGE_TIMEOUT_EN for an inter-byte timeout.
module uart_ahb_cmd_bridge #(
   parameter int XFER_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input logic                   hclk,
   input logic                   hreset,
   uart_ahb_cmd_bridge_if.master bus
);
   localparam logic [2:0] CMD  = 3'd0;
   localparam logic [2:0] ADDR = 3'd1;
   localparam logic [2:0] DATA = 3'd2;
   localparam logic [2:0] XFER = 3'd3;
   localparam logic [2:0] RESP = 3'd4;
   localparam logic [7:0] XFER_LAST = 8'(XFER_CYCLES - 1);

   if (XFER_CYCLES < 1 || XFER_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : gBadParam
      $error("uart_ahb_cmd_bridge: parameter out of range");
   end

   logic [2:0]  state_q, state_d;
   logic [1:0]  byteCnt_q, byteCnt_d;
   logic [7:0]  xferCnt_q, xferCnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic [1:0]  sel_q, sel_d;
   logic        badCmd_q, badCmd_d;
   logic [31:0] resp_q, resp_d;
   logic        txValid_q, txValid_d;
   logic        rxDrop_q, rxDrop_d;
   logic        respLast;
   logic        timeoutHit;

`ifdef BRIDGE_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [IDLE_W-1:0] idle_q;

   assign timeoutHit = (state_q == ADDR || state_q == DATA) && !bus.rx_valid &&
                       (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge hclk) begin
      if (hreset || bus.rx_valid || !(state_q == ADDR || state_q == DATA)) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_q + 1'b1;
      end
   end
`else
   assign timeoutHit = 1'b0;
`endif

   // Response bytes leave from the top of resp_q; single-byte replies end after one accept.
   assign respLast = wr_q || badCmd_q || (byteCnt_q == 2'd3);

   always_comb begin
      state_d   = state_q;
      byteCnt_d = byteCnt_q;
      xferCnt_d = xferCnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      sel_d     = sel_q;
      badCmd_d  = badCmd_q;
      resp_d    = resp_q;
      txValid_d = txValid_q;
      rxDrop_d  = bus.rx_valid && (state_q == XFER || state_q == RESP);
      case (state_q)
         CMD: begin
            if (bus.rx_valid) begin
               byteCnt_d = 2'd0;
               if (bus.rx_data[6:2] != 5'd0) begin
                  badCmd_d  = 1'b1;
                  resp_d    = {8'hEE, 24'h0};
                  txValid_d = 1'b1;
                  state_d   = RESP;
               end else begin
                  badCmd_d = 1'b0;
                  wr_d     = bus.rx_data[7];
                  sel_d    = bus.rx_data[1:0];
                  state_d  = ADDR;
               end
            end
         end
         ADDR: begin
            if (bus.rx_valid) begin
               addr_d    = {addr_q[23:0], bus.rx_data};
               byteCnt_d = byteCnt_q + 2'd1;
               if (byteCnt_q == 2'd3) begin
                  xferCnt_d = 8'd0;
                  state_d   = wr_q ? DATA : XFER;
               end
            end
         end
         DATA: begin
            if (bus.rx_valid) begin
               wdata_d   = {wdata_q[23:0], bus.rx_data};
               byteCnt_d = byteCnt_q + 2'd1;
               if (byteCnt_q == 2'd3) begin
                  xferCnt_d = 8'd0;
                  state_d   = XFER;
               end
            end
         end
         XFER: begin
            if (xferCnt_q == XFER_LAST) begin
               resp_d    = wr_q ? {8'hA5, 24'h0} : bus.ext_mast_dout;
               byteCnt_d = 2'd0;
               txValid_d = 1'b1;
               state_d   = RESP;
            end else begin
               xferCnt_d = xferCnt_q + 8'd1;
            end
         end
         RESP: begin
            if (txValid_q && bus.tx_ready) begin
               if (respLast) begin
                  txValid_d = 1'b0;
                  state_d   = CMD;
               end else begin
                  byteCnt_d = byteCnt_q + 2'd1;
                  resp_d    = {resp_q[23:0], 8'h00};
               end
            end
         end
         default: state_d = CMD;
      endcase
      if (timeoutHit) begin
         byteCnt_d = 2'd0;
         state_d   = CMD;
      end
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q   <= CMD;
         byteCnt_q <= 2'd0;
         xferCnt_q <= 8'd0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         wr_q      <= 1'b0;
         sel_q     <= 2'd0;
         badCmd_q  <= 1'b0;
         resp_q    <= 32'h0;
         txValid_q <= 1'b0;
         rxDrop_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         byteCnt_q <= byteCnt_d;
         xferCnt_q <= xferCnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wr_q      <= wr_d;
         sel_q     <= sel_d;
         badCmd_q  <= badCmd_d;
         resp_q    <= resp_d;
         txValid_q <= txValid_d;
         rxDrop_q  <= rxDrop_d;
      end
   end

   assign bus.tx_data        = resp_q[31:24];
   assign bus.tx_valid       = txValid_q;
   assign bus.ext_addr       = addr_q;
   assign bus.ext_mast_din   = wdata_q;
   assign bus.ext_wr         = wr_q;
   assign bus.ext_slv_sel_in = sel_q;
   assign bus.ext_enable     = (state_q == XFER);
   assign bus.ext_hbusreq_in = (state_q == XFER);
   assign bus.busy           = (state_q != CMD);
   assign bus.rx_drop        = rxDrop_q;
endmodule

// File: tb/tb_uart_ahb_cmd_bridge.sv
// Bench for uart_ahb_cmd_bridge: a frame/queue-level model checked every cycle, directed
// frames with literal expectations, then randomized frames. Honors BRIDGE_TIMEOUT_EN.
module tb_uart_ahb_cmd_bridge;
   localparam int XFER = 4;
   localparam int TMO  = 10;

   logic hclk   = 1'b0;
   logic hreset = 1'b1;
   uart_ahb_cmd_bridge_if bus();

   uart_ahb_cmd_bridge #(.XFER_CYCLES(XFER), .TIMEOUT_CYCLES(TMO)) dut (
      .hclk  (hclk),
      .hreset(hreset),
      .bus   (bus)
   );

   always #5 hclk = ~hclk;

   int total = 0;
   int bad   = 0;

   logic [7:0]  frame[$];
   logic [7:0]  resp[$];
   int          xferLeft = 0;
   int          idle = 0;
   logic        mDrop = 1'b0;
   logic [31:0] mAddr = 32'h0, mDin = 32'h0;
   logic        mWr = 1'b0;
   logic [1:0]  mSel = 2'd0;
   logic [7:0]  mCmd;

   logic [7:0]  txLog[$];
   int          enCount = 0, dropCount = 0;
   logic [31:0] snapAddr = 32'h0, snapDin = 32'h0;
   logic        snapWr = 1'b0;
   logic [1:0]  snapSel = 2'd0;
   int          readyMode = 1;
   logic        randDout = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: a frame is a byte queue, a transfer a countdown, a response a byte queue.
   always @(posedge hclk) begin
      if (hreset) begin
         frame.delete();
         resp.delete();
         xferLeft = 0;
         idle     = 0;
         mDrop    = 1'b0;
         mAddr    = 32'h0;
         mDin     = 32'h0;
         mWr      = 1'b0;
         mSel     = 2'd0;
      end else begin
         mDrop = bus.rx_valid && (xferLeft > 0 || resp.size() > 0);
         if (xferLeft > 0) begin
            xferLeft--;
            if (xferLeft == 0) begin
               if (mWr) resp.push_back(8'hA5);
               else for (int i = 3; i >= 0; i--) resp.push_back(bus.ext_mast_dout[8*i +: 8]);
            end
         end else if (resp.size() > 0) begin
            if (bus.tx_ready) void'(resp.pop_front());
         end else if (bus.rx_valid) begin
            frame.push_back(bus.rx_data);
            idle = 0;
            mCmd = frame[0];
            if (mCmd[6:2] != 5'd0) begin
               frame.delete();
               resp.push_back(8'hEE);
            end else if (frame.size() == (mCmd[7] ? 9 : 5)) begin
               mWr   = mCmd[7];
               mSel  = mCmd[1:0];
               mAddr = {frame[1], frame[2], frame[3], frame[4]};
               if (mWr) mDin = {frame[5], frame[6], frame[7], frame[8]};
               xferLeft = XFER;
               frame.delete();
            end
         end else if (frame.size() > 0) begin
`ifdef BRIDGE_TIMEOUT_EN
            idle++;
            if (idle == TMO) begin
               frame.delete();
               idle = 0;
            end
`endif
         end
      end
   end

   always @(posedge hclk) begin
      #1;
      if (!hreset) begin
         checkOutput("busy", bus.busy, (frame.size() > 0 || xferLeft > 0 || resp.size() > 0));
         checkOutput("ext_enable", bus.ext_enable, xferLeft > 0);
         checkOutput("ext_hbusreq_in", bus.ext_hbusreq_in, xferLeft > 0);
         checkOutput("tx_valid", bus.tx_valid, resp.size() > 0);
         checkOutput("rx_drop", bus.rx_drop, mDrop);
         if (resp.size() > 0) checkOutput("tx_data", bus.tx_data, resp[0]);
         if (xferLeft > 0) begin
            checkOutput("ext_addr", bus.ext_addr, mAddr);
            checkOutput("ext_mast_din", bus.ext_mast_din, mDin);
            checkOutput("ext_wr", bus.ext_wr, mWr);
            checkOutput("ext_slv_sel_in", bus.ext_slv_sel_in, mSel);
         end
      end
   end

   always @(posedge hclk) begin
      if (!hreset) begin
         if (bus.tx_valid && bus.tx_ready) txLog.push_back(bus.tx_data);
         if (bus.rx_drop) dropCount++;
         if (bus.ext_enable) begin
            enCount++;
            snapAddr = bus.ext_addr;
            snapDin  = bus.ext_mast_din;
            snapWr   = bus.ext_wr;
            snapSel  = bus.ext_slv_sel_in;
         end
      end
   end

   always @(negedge hclk) begin
      if (readyMode == 0) bus.tx_ready = ($urandom_range(0, 3) != 0);
      if (randDout) bus.ext_mast_dout = $urandom;
   end

   task automatic clearLog();
      txLog.delete();
      enCount   = 0;
      dropCount = 0;
   endtask

   task automatic sendByte(input logic [7:0] b, input int gap);
      repeat (gap) @(negedge hclk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge hclk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
   endtask

   task automatic applyStimulus(input logic [7:0] bytes[$], input int maxGap);
      foreach (bytes[i]) sendByte(bytes[i], $urandom_range(0, maxGap));
   endtask

   task automatic waitIdle();
      int n = 0;
      while ((bus.busy || resp.size() > 0 || xferLeft > 0) && n < 300) begin
         @(negedge hclk);
         n++;
      end
      if (n >= 300) begin
         total++;
         bad++;
         $display("[TB] FAIL idle_wait: still busy after %0d cycles, required idle", n);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_busy"}, bus.busy, 0);
      checkOutput({tag, "_tx_valid"}, bus.tx_valid, 0);
      checkOutput({tag, "_tx_data"}, bus.tx_data, 0);
      checkOutput({tag, "_ext_addr"}, bus.ext_addr, 0);
      checkOutput({tag, "_ext_mast_din"}, bus.ext_mast_din, 0);
      checkOutput({tag, "_ext_wr"}, bus.ext_wr, 0);
      checkOutput({tag, "_ext_slv_sel_in"}, bus.ext_slv_sel_in, 0);
      checkOutput({tag, "_ext_enable"}, bus.ext_enable, 0);
      checkOutput({tag, "_ext_hbusreq_in"}, bus.ext_hbusreq_in, 0);
      checkOutput({tag, "_rx_drop"}, bus.rx_drop, 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] q[$];
      logic [7:0] c;
      int n;
      bus.rx_valid      = 1'b0;
      bus.rx_data       = 8'h00;
      bus.tx_ready      = 1'b1;
      bus.ext_mast_dout = 32'h0;
      hreset = 1'b1;
      repeat (3) @(negedge hclk);
      checkReset("por");
      hreset = 1'b0;
      @(negedge hclk);

      clearLog();
      q = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      applyStimulus(q, 0);
      waitIdle();
      checkOutput("wr_en_cycles", enCount, 4);
      checkOutput("wr_addr", snapAddr, 32'h0000_0010);
      checkOutput("wr_din", snapDin, 32'hDEAD_BEEF);
      checkOutput("wr_wr", snapWr, 1);
      checkOutput("wr_sel", snapSel, 2'b01);
      checkOutput("wr_tx_count", txLog.size(), 1);
      if (txLog.size() == 1) checkOutput("wr_tx_byte", txLog[0], 8'hA5);

      clearLog();
      bus.ext_mast_dout = 32'h1234_5678;
      q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h20};
      applyStimulus(q, 1);
      n = 0;
      while (txLog.size() < 1 && n < 100) begin
         @(negedge hclk);
         n++;
      end
      checkOutput("rd_first_byte_seen", txLog.size(), 1);
      bus.tx_ready = 1'b0;
      repeat (3) begin
         @(negedge hclk);
         checkOutput("rd_stall_valid", bus.tx_valid, 1);
         checkOutput("rd_stall_data", bus.tx_data, 8'h34);
      end
      bus.tx_ready = 1'b1;
      waitIdle();
      checkOutput("rd_en_cycles", enCount, 4);
      checkOutput("rd_addr", snapAddr, 32'h0000_0020);
      checkOutput("rd_wr", snapWr, 0);
      checkOutput("rd_sel", snapSel, 2'b10);
      checkOutput("rd_tx_count", txLog.size(), 4);
      if (txLog.size() == 4)
         checkOutput("rd_tx_bytes", {txLog[0], txLog[1], txLog[2], txLog[3]}, 32'h1234_5678);

      clearLog();
      sendByte(8'h44, 0);
      waitIdle();
      checkOutput("bad_en_cycles", enCount, 0);
      checkOutput("bad_tx_count", txLog.size(), 1);
      if (txLog.size() == 1) checkOutput("bad_tx_byte", txLog[0], 8'hEE);

      clearLog();
      q = '{8'h83, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      applyStimulus(q, 0);
      sendByte(8'h55, 1);
      waitIdle();
      checkOutput("drop_count", dropCount, 1);
      checkOutput("drop_en_cycles", enCount, 4);
      checkOutput("drop_din", snapDin, 32'h1122_3344);
      checkOutput("drop_tx_count", txLog.size(), 1);

      clearLog();
      sendByte(8'h02, 0);
      sendByte(8'h00, 0);
      sendByte(8'h00, 0);
      hreset = 1'b1;
      @(negedge hclk);
      checkReset("mid");
      hreset = 1'b0;
      bus.ext_mast_dout = 32'hCAFE_F00D;
      q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h40};
      applyStimulus(q, 2);
      waitIdle();
      checkOutput("post_rst_addr", snapAddr, 32'h0000_0040);
      checkOutput("post_rst_tx_count", txLog.size(), 4);
      if (txLog.size() == 4)
         checkOutput("post_rst_tx_bytes", {txLog[0], txLog[1], txLog[2], txLog[3]}, 32'hCAFE_F00D);

      clearLog();
      bus.tx_ready = 1'b0;
      q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h44};
      applyStimulus(q, 0);
      n = 0;
      while (!bus.tx_valid && n < 50) begin
         @(negedge hclk);
         n++;
      end
      checkOutput("resp_rst_valid_seen", bus.tx_valid, 1);
      hreset = 1'b1;
      @(negedge hclk);
      checkReset("resp");
      hreset = 1'b0;
      bus.tx_ready = 1'b1;
      repeat (4) @(negedge hclk);
      checkOutput("resp_rst_abandoned", txLog.size(), 0);

`ifdef BRIDGE_TIMEOUT_EN
      clearLog();
      sendByte(8'h81, 0);
      sendByte(8'h00, 0);
      for (int i = 1; i < TMO; i++) begin
         @(negedge hclk);
         checkOutput("tmo_still_busy", bus.busy, 1);
      end
      @(negedge hclk);
      checkOutput("tmo_back_to_cmd", bus.busy, 0);
      checkOutput("tmo_no_tx", txLog.size(), 0);
      q = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04};
      applyStimulus(q, 3);
      waitIdle();
      checkOutput("tmo_next_din", snapDin, 32'h0102_0304);
      checkOutput("tmo_next_tx_count", txLog.size(), 1);
`endif

      readyMode = 0;
      randDout  = 1'b1;
      for (int f = 0; f < 40; f++) begin
         q.delete();
         if ($urandom_range(0, 7) == 0) begin
            c = 8'($urandom);
            if (c[6:2] == 5'd0) c[2] = 1'b1;
            q.push_back(c);
         end else begin
            c = {1'($urandom), 5'd0, 2'($urandom)};
            q.push_back(c);
            repeat (c[7] ? 8 : 4) q.push_back(8'($urandom));
         end
         applyStimulus(q, 3);
         if (q.size() > 1 && $urandom_range(0, 2) == 0) sendByte(8'($urandom), $urandom_range(0, 4));
         waitIdle();
         repeat ($urandom_range(0, 3)) @(negedge hclk);
      end
      readyMode = 1;
      randDout  = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_ahb_cmd_bridge.md
UART_AHB_CMD_BRIDGE -- requirements
Module: uart_ahb_cmd_bridge

Interface
REQ-001 Parameter XFER_CYCLES, default 4, number of cycles ext_enable/ext_hbusreq_in are held per transfer (legal 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000, inter-byte idle limit used only when BRIDGE_TIMEOUT_EN is defined.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 hclk  in  1  clock; all logic on its rising edge.
REQ-005 hreset  in  1  synchronous reset, active-high.
REQ-006 rx_data  in  8  received UART byte.
REQ-007 rx_valid  in  1  one-cycle strobe, rx_data valid.
REQ-008 tx_data  out  8  response byte to UART transmitter.
REQ-009 tx_valid  out  1  tx_data valid; held until tx_ready.
REQ-010 tx_ready  in  1  transmitter accepts tx_data when high with tx_valid.
REQ-011 ext_addr  out  32  transfer address to external master port.
REQ-012 ext_slv_sel_in  out  2  target slave select.
REQ-013 ext_mast_din  out  32  write data.
REQ-014 ext_wr  out  1  1 = write, 0 = read.
REQ-015 ext_enable  out  1  transfer enable to external master.
REQ-016 ext_hbusreq_in  out  1  bus request to arbiter.
REQ-017 ext_mast_dout  in  32  read data returned by external master.
REQ-018 busy  out  1  high in any state except CMD.
REQ-019 rx_drop  out  1  one-cycle pulse when an rx_valid byte is discarded.

Function
REQ-020 States: CMD, ADDR, DATA, XFER, RESP; CMD after reset.
REQ-021 Command byte in CMD: bit7 = wr, bits1:0 = slave select, bits6:2 must be 0.
REQ-022 Command with bits6:2 nonzero: no transfer; RESP sends single byte 0xEE.
REQ-023 ADDR accepts 4 bytes MSB first into ext_addr; counter 0..3.
REQ-024 After 4th address byte: wr=1 -> DATA; wr=0 -> XFER next cycle.
REQ-025 DATA accepts 4 bytes MSB first into ext_mast_din; after 4th byte -> XFER next cycle.
REQ-026 ext_addr, ext_mast_din, ext_wr, ext_slv_sel_in registered; stable throughout XFER; hold last values until next command overwrites them.
REQ-027 XFER: ext_enable = ext_hbusreq_in = 1 for exactly XFER_CYCLES cycles, starting the cycle after the last frame byte.
REQ-028 Read: ext_mast_dout captured on the last XFER cycle; both strobes low the following cycle, state RESP.
REQ-029 RESP write: one byte 0xA5. RESP read: 4 captured bytes MSB first.
REQ-030 tx_valid asserts on RESP entry; byte advances only on tx_valid && tx_ready; tx_data stable while tx_ready is low.
REQ-031 Acceptance of the last response byte -> CMD next cycle, tx_valid low.
REQ-032 rx_valid in XFER or RESP: byte ignored, rx_drop pulses, state unchanged.
REQ-033 rx_valid with no state change: no output change except rx_drop where applicable.

Reset
REQ-034 hreset high at any edge, including mid-frame or mid-XFER: state CMD; counters 0; ext_addr, ext_mast_din = 0; ext_slv_sel_in = 0; ext_wr, ext_enable, ext_hbusreq_in, tx_valid, busy, rx_drop = 0; tx_data = 0x00.
REQ-035 A partially sent response is abandoned on reset, not resumed.

Configuration
REQ-036 Macro BRIDGE_TIMEOUT_EN: when defined, an idle counter in ADDR/DATA clears on each rx_valid; reaching TIMEOUT_CYCLES -> CMD, partial frame discarded, no response.
REQ-037 Without BRIDGE_TIMEOUT_EN: ADDR/DATA wait indefinitely; no timeout counter is synthesized.

Verification
REQ-038 Write: bytes 0x81,00,00,00,10,DE,AD,BE,EF -> ext_addr=0x00000010, ext_mast_din=0xDEADBEEF, ext_wr=1, ext_slv_sel_in=01, enable high 4 cycles; tx 0xA5.
REQ-039 Read: 0x02,00,00,00,20 with ext_mast_dout=0x12345678 -> enable 4 cycles, wr=0, sel=10; tx 12,34,56,78; tx_ready low 3 cycles mid-stream holds the byte.
REQ-040 Bad command 0x44 -> no ext_enable; tx 0xEE; back to CMD.
REQ-041 rx_valid during XFER -> rx_drop pulse; transfer and response unaffected.
REQ-042 hreset after 2 address bytes -> all outputs at reset values; subsequent full read frame completes normally.
REQ-043 BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=10: 0x81,00 then 10 idle cycles -> CMD, no tx; next frame completes correctly.
